// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side consumer for an async FIFO, read clock domain only.
// Issues FIFO reads while data is available and the 2-entry skid buffer has
// room (counting the read already in flight), captures the registered FIFO
// data one cycle later, and presents the buffer head as a valid/ready stream.
//
// Ports:
//   rclk      read-domain clock
//   r_rst     synchronous reset, active high
//   drain_en  permit new FIFO reads
//   empty     FIFO empty flag (rclk domain)
//   data_out  FIFO read data, valid the cycle after an accepted r_en
//   r_en      FIFO read enable (combinational)
//   m_valid   downstream valid, buffer head present
//   m_ready   downstream ready
//   m_data    buffer head
//   word_cnt  words delivered downstream, wraps
//   busy      buffer not empty or a read is in flight
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  drain_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  head_q, tail_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  pop;

  always_comb begin
    // Outputs are forced quiet while reset is held, even mid-operation.
    m_valid  = !r_rst && (occ_q != 2'd0);
    m_data   = r_rst ? '0 : mem_q[head_q];
    busy     = !r_rst && ((occ_q != 2'd0) || inflight_q);
    word_cnt = cnt_q;
    pop      = m_valid && m_ready;
    // occ_d is also the committed fill (buffered + arriving - leaving); a new
    // read is only safe if that fill leaves a free slot for its data.
    // Never exceeds 2, so 2 bits suffice.
    occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    r_en     = !r_rst && drain_en && !empty && (occ_d < 2'd2);
  end

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= r_en;
      if (inflight_q) begin
        mem_q[tail_q] <= data_out;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Testbench for fifo_rd_drain: a table of hand-computed cycle vectors, then
// multi-cycle sequences driven from a small queue standing in for the FIFO.
module tb_fifo_rd_drain;

  logic        rclk = 1'b0;
  logic        r_rst = 1'b1;
  logic        drain_en = 1'b0;
  logic        empty = 1'b1;
  logic [7:0]  data_out = 8'h00;
  logic        m_ready = 1'b0;
  logic        r_en, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;
  logic        r_en4, m_valid4, busy4;
  logic [7:0]  m_data4;
  logic [3:0]  word_cnt4;

  always #5 rclk = ~rclk;

  fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .r_rst(r_rst), .drain_en(drain_en), .empty(empty),
    .data_out(data_out), .r_en(r_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .word_cnt(word_cnt), .busy(busy));

  // Narrow-counter copy sharing all inputs, used for the wrap check.
  fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .rclk(rclk), .r_rst(r_rst), .drain_en(drain_en), .empty(empty),
    .data_out(data_out), .r_en(r_en4), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .word_cnt(word_cnt4), .busy(busy4));

  typedef struct {
    logic       rst, drn, emp, rdy;
    logic [7:0] din;
    logic       ren, mv;
    logic [7:0] md;
    logic       bsy;
    logic [15:0] cnt;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO stand-in and per-cycle bookkeeping
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic       hold_empty = 1'b0;
  logic       s_ren, s_mv, s_bsy, s_emp;
  logic [7:0] s_md;
  logic [15:0] s_cnt;
  logic [3:0] s_cnt4;
  int cyc_n, first_ren, first_vld, first_pop, last_pop, ren_cnt, n_iss, n_del;

  task automatic clr_stats();
    got.delete();
    cyc_n = 0; first_ren = -1; first_vld = -1; first_pop = -1; last_pop = -1;
    ren_cnt = 0;
  endtask

  // One clock cycle: present empty, sample outputs mid-cycle, then deliver
  // the registered read data just after the edge.
  task automatic cyc();
    @(negedge rclk);
    empty = hold_empty || (q.size() == 0);
    #1;
    s_ren = r_en; s_mv = m_valid; s_md = m_data; s_bsy = busy;
    s_cnt = word_cnt; s_cnt4 = word_cnt4; s_emp = empty;
    chk("ren_while_empty", {31'd0, s_ren && s_emp}, 32'd0);
    if (r_rst) begin
      n_iss = 0; n_del = 0;
    end else begin
      chk("overflow", {31'd0, (n_iss - n_del) <= 2}, 32'd1);
      if (s_ren) begin n_iss++; ren_cnt++; if (first_ren < 0) first_ren = cyc_n; end
      if (s_mv && first_vld < 0) first_vld = cyc_n;
      if (s_mv && m_ready) begin
        got.push_back(s_md); n_del++;
        if (first_pop < 0) first_pop = cyc_n;
        last_pop = cyc_n;
      end
    end
    cyc_n++;
    @(posedge rclk); #1;
    if (s_ren) begin
      if (q.size() > 0) data_out = q.pop_front();
      else chk("model_underflow", 32'd1, 32'd0);
    end
  endtask

  task automatic do_reset();
    r_rst = 1'b1; q.delete();
    repeat (3) begin
      cyc();
      chk("rst_ren", {31'd0, s_ren}, 32'd0);
      chk("rst_mvalid", {31'd0, s_mv}, 32'd0);
      chk("rst_mdata", {24'd0, s_md}, 32'd0);
    end
    chk("rst_cnt", {16'd0, s_cnt}, 32'd0);
    r_rst = 1'b0;
    clr_stats();
  endtask

  vec_t tbl[15];

  initial begin
    //          rst drn emp rdy din    ren mv md     bsy cnt
    tbl[0]  = '{1, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 16'd0};
    tbl[1]  = '{1, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 16'd0};
    tbl[2]  = '{1, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 16'd0};
    tbl[3]  = '{0, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0, 16'd0};
    tbl[4]  = '{0, 1, 0, 1, 8'h11, 1, 0, 8'h00, 1, 16'd0};
    tbl[5]  = '{0, 1, 0, 1, 8'h22, 1, 1, 8'h11, 1, 16'd0};
    tbl[6]  = '{0, 1, 0, 0, 8'h33, 0, 1, 8'h22, 1, 16'd1};
    tbl[7]  = '{0, 1, 0, 0, 8'h44, 0, 1, 8'h22, 1, 16'd1};
    tbl[8]  = '{0, 1, 0, 1, 8'h44, 1, 1, 8'h22, 1, 16'd1};
    tbl[9]  = '{0, 0, 0, 0, 8'h55, 0, 1, 8'h33, 1, 16'd2};
    tbl[10] = '{0, 0, 0, 1, 8'h66, 0, 1, 8'h33, 1, 16'd2};
    tbl[11] = '{0, 1, 1, 1, 8'h66, 0, 1, 8'h55, 1, 16'd3};
    tbl[12] = '{0, 1, 1, 1, 8'h66, 0, 0, 8'h33, 0, 16'd4};
    tbl[13] = '{1, 1, 0, 1, 8'h66, 0, 0, 8'h00, 0, 16'd4};
    tbl[14] = '{0, 1, 1, 1, 8'h66, 0, 0, 8'h00, 0, 16'd0};

    for (int i = 0; i < 15; i++) begin
      @(negedge rclk);
      r_rst = tbl[i].rst; drain_en = tbl[i].drn; empty = tbl[i].emp;
      m_ready = tbl[i].rdy; data_out = tbl[i].din;
      #1;
      chk($sformatf("v%0d_r_en", i), {31'd0, r_en}, {31'd0, tbl[i].ren});
      chk($sformatf("v%0d_m_valid", i), {31'd0, m_valid}, {31'd0, tbl[i].mv});
      chk($sformatf("v%0d_m_data", i), {24'd0, m_data}, {24'd0, tbl[i].md});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      chk($sformatf("v%0d_cnt", i), {16'd0, word_cnt}, {16'd0, tbl[i].cnt});
      chk($sformatf("v%0d_cnt4", i), {28'd0, word_cnt4}, {28'd0, tbl[i].cnt[3:0]});
    end

    // Streaming: 16 words, ready held high
    drain_en = 1'b1; m_ready = 1'b1;
    do_reset();
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    repeat (20) cyc();
    chk("stream_latency", first_vld - first_ren, 32'd2);
    chk("stream_no_bubbles", last_pop - first_pop, 32'd15);
    chk("stream_count", got.size(), 32'd16);
    for (int i = 0; i < got.size() && i < 16; i++)
      chk($sformatf("stream_d%0d", i), {24'd0, got[i]}, i + 1);
    chk("stream_cnt", {16'd0, s_cnt}, 32'd16);
    chk("stream_idle_ren", {31'd0, s_ren}, 32'd0);
    chk("stream_idle_busy", {31'd0, s_bsy}, 32'd0);

    // Backpressure: 8 words, ready low, then released
    m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'hA0 + 8'(i));
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (c >= 2) begin
        chk("bp_valid", {31'd0, s_mv}, 32'd1);
        chk("bp_hold", {24'd0, s_md}, 32'hA0);
      end
    end
    chk("bp_ren_pulses", ren_cnt, 32'd2);
    chk("bp_outstanding", n_iss - n_del, 32'd2);
    m_ready = 1'b1;
    repeat (14) cyc();
    chk("bp_count", got.size(), 32'd8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk($sformatf("bp_d%0d", i), {24'd0, got[i]}, 32'hA0 + i);

    // Alternating ready over 32 words
    do_reset();
    for (int i = 0; i < 32; i++) q.push_back(8'((i * 7 + 3) & 8'hFF));
    for (int c = 0; c < 120 && got.size() < 32; c++) begin
      m_ready = c[0] ? 1'b0 : 1'b1;
      cyc();
    end
    chk("alt_count", got.size(), 32'd32);
    for (int i = 0; i < got.size() && i < 32; i++)
      chk($sformatf("alt_d%0d", i), {24'd0, got[i]}, (i * 7 + 3) & 8'hFF);
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("alt_cnt", {16'd0, s_cnt}, 32'd32);

    // Drain disabled one cycle after the first read
    do_reset();
    for (int i = 0; i < 5; i++) q.push_back(8'hC0 + 8'(i));
    cyc();
    chk("dis_first_ren", {31'd0, s_ren}, 32'd1);
    drain_en = 1'b0;
    repeat (6) cyc();
    chk("dis_ren_count", ren_cnt, 32'd1);
    chk("dis_delivered", got.size(), 32'd1);
    if (got.size() > 0) chk("dis_word", {24'd0, got[0]}, 32'hC0);
    chk("dis_cnt", {16'd0, s_cnt}, 32'd1);
    q.delete();

    // Reset with the buffer full
    for (int i = 0; i < 4; i++) q.push_back(8'hD0 + 8'(i));
    drain_en = 1'b1; m_ready = 1'b0; ren_cnt = 0;
    repeat (4) cyc();
    chk("full_ren_count", ren_cnt, 32'd2);
    chk("full_valid", {31'd0, s_mv}, 32'd1);
    chk("full_head", {24'd0, s_md}, 32'hD0);
    r_rst = 1'b1;
    cyc();
    r_rst = 1'b0; hold_empty = 1'b1;
    cyc();
    chk("rstfull_valid", {31'd0, s_mv}, 32'd0);
    chk("rstfull_cnt", {16'd0, s_cnt}, 32'd0);
    chk("rstfull_busy", {31'd0, s_bsy}, 32'd0);
    hold_empty = 1'b0;

    // Counter wrap: 17 words into the 4-bit counter
    m_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) q.push_back(8'(i + 'h40));
    repeat (24) cyc();
    chk("wrap_count", got.size(), 32'd17);
    chk("wrap_cnt4", {28'd0, s_cnt4}, 32'd1);
    chk("wrap_cnt16", {16'd0, s_cnt}, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer for the async FIFO. It runs entirely in the read clock domain.
- Issues r_en whenever the FIFO holds data and there is downstream room, and captures the registered FIFO read data into a 2-entry skid buffer.
- Presents the data downstream on a valid/ready stream and counts the words delivered.
- Sits between the FIFO read port (empty, data_out) and the consuming logic.

Parameters:
- DATA_WIDTH, 8, width of FIFO data_out and m_data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- rclk  input  1  read-domain clock, shared with FIFO read side.
- r_rst  input  1  synchronous reset, active-high.
- drain_en  input  1  1 = allowed to issue new FIFO reads.
- empty  input  1  FIFO empty flag, synchronous to rclk.
- data_out  input  DATA_WIDTH  FIFO read data, registered: valid the cycle after an accepted r_en.
- r_en  output  1  FIFO read enable, combinational from internal state and inputs.
- m_valid  output  1  downstream data valid, head of skid buffer present.
- m_ready  input  1  downstream accepts when m_valid && m_ready.
- m_data  output  DATA_WIDTH  head of skid buffer.
- word_cnt  output  CNT_WIDTH  count of words delivered downstream (handshakes).
- busy  output  1  1 while occ != 0 or inflight == 1.

Behaviour:
- State registers:
  - occ (0..2): skid buffer occupancy.
  - inflight (0/1): a read was issued last cycle and its data arrives this cycle.
  - 2-entry buffer with head/tail index.
  - word_cnt.
- Reset (r_rst high at rclk edge): occ=0, inflight=0, buffer contents=0, word_cnt=0. Outputs during and after reset: m_valid=0, m_data=0, r_en=0, busy=0.
- pop = m_valid && m_ready.
- r_en = !r_rst && drain_en && !empty && (occ + inflight - pop) < 2.
  - r_en is never asserted while empty=1.
  - r_en is never asserted when the buffer could overflow.
- inflight_next = r_en.
- Capture: when inflight=1, data_out is written at tail that edge.
- Occupancy update each edge: occ_next = occ + inflight - pop. Push and pop in the same cycle leave occ unchanged.
- m_valid = (occ != 0). m_data = buffer[head]. The head advances on pop. Head and tail indices wrap modulo 2.
- Latency: first r_en in cycle t → data captured at end of t+1 → m_valid=1 in cycle t+2.
- Throughput: with m_ready held 1 and FIFO non-empty, one word per cycle steady-state, no bubbles.
- Backpressure: with m_ready=0, at most 2 words are buffered. Reads stop once occ + inflight = 2, and resume the cycle pop occurs.
- drain_en=0:
  - No new reads.
  - An in-flight word is still captured.
  - Buffered words still drain to downstream.
- empty toggling: each r_en is evaluated purely on the current cycle's empty. A late empty deassertion from pointer sync only delays reads; no word is lost or duplicated.
- word_cnt increments by 1 per pop and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation:
  - Buffered and in-flight data are discarded.
  - r_rst is the same reset applied to the FIFO read pointer.
  - The first cycle after reset release behaves as from cold start.
- m_data is held stable while m_valid && !m_ready.

Test Plan:
- Reset: assert r_rst 3 cycles with empty=0 and drain_en=1 → r_en=0, m_valid=0, m_data=0, word_cnt=0 throughout.
- Streaming: FIFO preloaded with 0x01..0x10, drain_en=1, m_ready=1 → first m_valid 2 cycles after first r_en; 16 consecutive beats 0x01..0x10; word_cnt=16; then empty=1 → r_en=0, busy=0.
- Backpressure: 8 words 0xA0..0xA7 in FIFO, m_ready=0 → exactly 2 r_en pulses, occ=2, m_data=0xA0 held stable. Release m_ready → all 8 words delivered in order, none lost or duplicated.
- Alternating ready: m_ready toggles 1/0 each cycle over 32 words → in-order delivery, r_en never asserted with empty=1, no overflow.
- Disable and reset:
  - drain_en dropped the cycle after an r_en → in-flight word still delivered; no further r_en.
  - r_rst pulsed with occ=2 → m_valid=0 next cycle; word_cnt=0.
- Counter wrap: with CNT_WIDTH=4, deliver 17 words → word_cnt reads 1.
